id_exe_stage: RTL and testbench
===============================

Name: id_exe_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, with the load-use hazard detector folded in.
- Captures decoded operands and control from ID and presents them to EX.
- Its EXE_rs1_addr, EXE_rs2_addr, EXE_rd_addr and EXE_RegWrite outputs feed the forwarding unit directly.
- Handles pipeline hold (memory wait), flush (taken branch/jump) and load-use bubble insertion. Drives the IF/ID hold request.

Parameters:
XLEN, 32, datapath width
CTRL_W, 12, width of packed EX/MEM/WB control bundle (ALU op, ALUSrc, MemWrite, MemtoReg, branch type, etc.)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_addr  in  5  source 1 index
id_rs2_addr  in  5  source 2 index
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd_addr  in  5  destination index
id_rs1_data  in  XLEN  register-file read 1
id_rs2_data  in  XLEN  register-file read 2
id_imm  in  XLEN  sign-extended immediate
id_ctrl  in  CTRL_W  packed control bundle
id_RegWrite  in  1  writes rd
id_MemRead  in  1  is a load
mem_stall  in  1  downstream hold (DM wait); freezes this stage
exe_flush  in  1  EX resolved taken branch/jump this cycle
ifid_hold  out  1  hold PC and IF/ID register (load-use)
EXE_valid  out  1  EX holds a real instruction
EXE_pc  out  XLEN  registered id_pc
EXE_rs1_addr  out  5  registered, to forwarding unit
EXE_rs2_addr  out  5  registered, to forwarding unit
EXE_rd_addr  out  5  registered, to forwarding unit
EXE_rs1_data  out  XLEN  registered
EXE_rs2_data  out  XLEN  registered
EXE_imm  out  XLEN  registered
EXE_ctrl  out  CTRL_W  registered
EXE_RegWrite  out  1  registered, qualified (see below)
EXE_MemRead  out  1  registered

Behaviour:
- Reset (rst_n low, asynchronous): all EXE_* outputs 0, including EXE_valid, RegWrite and MemRead. ifid_hold is combinational, so it is 0 after reset.
- Load-use detect, combinational:
  - hazard = EXE_valid & EXE_MemRead & (EXE_rd_addr != 0) & id_valid & ((id_rs1_used & id_rs1_addr == EXE_rd_addr) | (id_rs2_used & id_rs2_addr == EXE_rd_addr)).
- ifid_hold = hazard & ~exe_flush & ~mem_stall. mem_stall already freezes the front end globally.
- Per rising edge, first matching row wins:
  1. mem_stall=1: all registers hold. Flush and hazard are ignored this cycle; they re-evaluate next cycle.
  2. exe_flush=1: load bubble. EXE_valid, RegWrite, MemRead and the ctrl write-enables are set to 0; addresses are set to 0.
  3. hazard=1: load bubble as in row 2. The ID instruction stays in IF/ID (ifid_hold) and is captured next cycle. The stall lasts exactly 1 cycle, because the bubble clears EXE_MemRead.
  4. Otherwise: capture all id_* inputs. EXE_valid=id_valid.
- Qualified write-enable: EXE_RegWrite = id_RegWrite & id_valid & (id_rd_addr != 0). x0 is never a forwarding source.
- Latency: 1 cycle from ID to EX outputs. Throughput: 1 per cycle, except 1 bubble per load-use.
- Simultaneous flush and hazard: flush wins, and ifid_hold=0 because the ID instruction is squashed upstream.
- Reset asserted mid-stall: outputs clear immediately. No stall state persists.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined: adds outputs perf_lu_bubbles[31:0], perf_flushes[31:0] and perf_stall_cycles[31:0].
  - Counters increment on rows 3, 2 and 1 respectively.
  - Counters saturate at 0xFFFFFFFF and reset to 0 on rst_n.
- Undefined: the ports and counters do not exist and there is zero logic.

Decomposition:
- cpu_pkg holds:
  - typedef ctrl_t: packed struct, width CTRL_W.
  - localparam REG_X0=5'd0.
  - localparam CTRL_BUBBLE: all-zero ctrl_t.
- Sub-module hazard_detect: purely combinational. Computes hazard from the EXE_* feedback and the id_* inputs.
- id_exe_stage instantiates hazard_detect and contains all the registers.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with id_valid=1 -> all EXE_* go to 0 immediately, ifid_hold=0.
- Load-use: lw x5 in EX (EXE_MemRead=1, EXE_rd_addr=5), ID add x6,x5,x7 with rs1_used=1 -> ifid_hold=1 for 1 cycle. Next EXE_valid=0, EXE_RegWrite=0. The following cycle EXE_rs1_addr=5, EXE_valid=1.
- False-hazard guards:
  - rd=0 load with ID rs1=0 -> no stall.
  - ID rs2=5 with rs2_used=0 (I-type) -> no stall.
  - addi x0 in ID -> EXE_RegWrite=0.
- Flush priority: exe_flush=1 with hazard=1 -> bubble, ifid_hold=0, EXE_valid=0.
- mem_stall: hold 3 cycles with id_* changing and exe_flush=1 pulsed mid-hold -> EXE_* unchanged throughout. After release, normal capture resumes.
- HAZ_PERF_EN: 2 load-use events, 1 flush and 3 stall cycles -> counters read 2, 1, 3. Preload near 0xFFFFFFFF -> counters saturate.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I pipeline: operand widths, the packed
// EX/MEM/WB control bundle and the bubble value.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic [2:0] br_type;
    logic       jump;
    logic       mem_write;
    logic       mem_to_reg;
    logic       wb_sel_pc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Event counter that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/id_exe_stage_if.sv
// ID-to-EX boundary bundle: decoded operands/control in, registered EX view and
// the IF/ID hold request out. The stage uses 'slave'; the ID/EX neighbours use 'master'.
interface id_exe_stage_if;
  import cpu_pkg::*;

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1_addr;
  logic [4:0]        id_rs2_addr;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [4:0]        id_rd_addr;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  ctrl_t             id_ctrl;
  logic              id_RegWrite;
  logic              id_MemRead;
  logic              mem_stall;
  logic              exe_flush;

  logic              ifid_hold;
  logic              EXE_valid;
  logic [XLEN-1:0]   EXE_pc;
  logic [4:0]        EXE_rs1_addr;
  logic [4:0]        EXE_rs2_addr;
  logic [4:0]        EXE_rd_addr;
  logic [XLEN-1:0]   EXE_rs1_data;
  logic [XLEN-1:0]   EXE_rs2_data;
  logic [XLEN-1:0]   EXE_imm;
  ctrl_t             EXE_ctrl;
  logic              EXE_RegWrite;
  logic              EXE_MemRead;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rs1_data, id_rs2_data, id_imm, id_ctrl, id_RegWrite,
           id_MemRead, mem_stall, exe_flush,
    input  ifid_hold, EXE_valid, EXE_pc, EXE_rs1_addr, EXE_rs2_addr, EXE_rd_addr,
           EXE_rs1_data, EXE_rs2_data, EXE_imm, EXE_ctrl, EXE_RegWrite, EXE_MemRead
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rs1_data, id_rs2_data, id_imm, id_ctrl, id_RegWrite,
           id_MemRead, mem_stall, exe_flush,
    output ifid_hold, EXE_valid, EXE_pc, EXE_rs1_addr, EXE_rs2_addr, EXE_rd_addr,
           EXE_rs1_data, EXE_rs2_data, EXE_imm, EXE_ctrl, EXE_RegWrite, EXE_MemRead
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose rd feeds a source the ID
// instruction actually reads. Purely combinational.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       i_exe_valid,
  input  logic       i_exe_mem_read,
  input  logic [4:0] i_exe_rd_addr,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  output logic       o_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_load_in_ex;

  assign w_load_in_ex = i_exe_valid & i_exe_mem_read & (i_exe_rd_addr != REG_X0);
  assign w_rs1_match  = i_id_rs1_used & (i_id_rs1_addr == i_exe_rd_addr);
  assign w_rs2_match  = i_id_rs2_used & (i_id_rs2_addr == i_exe_rd_addr);
  assign o_hazard     = w_load_in_ex & i_id_valid & (w_rs1_match | w_rs2_match);

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and memory hold.
// Optional macro HAZ_PERF_EN adds saturating bubble/flush/stall counters.
module id_exe_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  id_exe_stage_if.slave        bus
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]          perf_lu_bubbles,
  output logic [31:0]          perf_flushes,
  output logic [31:0]          perf_stall_cycles
`endif
);

  logic            w_hazard;
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1_addr;
  logic [4:0]      r_rs2_addr;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  ctrl_t           r_ctrl;
  logic            r_regwrite;
  logic            r_memread;

  hazard_detect u_hazard_detect (
    .i_exe_valid    (r_valid),
    .i_exe_mem_read (r_memread),
    .i_exe_rd_addr  (r_rd_addr),
    .i_id_valid     (bus.id_valid),
    .i_id_rs1_addr  (bus.id_rs1_addr),
    .i_id_rs2_addr  (bus.id_rs2_addr),
    .i_id_rs1_used  (bus.id_rs1_used),
    .i_id_rs2_used  (bus.id_rs2_used),
    .o_hazard       (w_hazard)
  );

  // A flushed ID instruction is squashed upstream, so it must not be held.
  assign bus.ifid_hold = w_hazard & ~bus.exe_flush & ~bus.mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_addr <= REG_X0;
      r_rs2_addr <= REG_X0;
      r_rd_addr  <= REG_X0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_ctrl     <= CTRL_BUBBLE;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
    end else if (!bus.mem_stall) begin
      if (bus.exe_flush || w_hazard) begin
        r_valid    <= 1'b0;
        r_pc       <= '0;
        r_rs1_addr <= REG_X0;
        r_rs2_addr <= REG_X0;
        r_rd_addr  <= REG_X0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_ctrl     <= CTRL_BUBBLE;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
      end else begin
        r_valid    <= bus.id_valid;
        r_pc       <= bus.id_pc;
        r_rs1_addr <= bus.id_rs1_addr;
        r_rs2_addr <= bus.id_rs2_addr;
        r_rd_addr  <= bus.id_rd_addr;
        r_rs1_data <= bus.id_rs1_data;
        r_rs2_data <= bus.id_rs2_data;
        r_imm      <= bus.id_imm;
        r_ctrl     <= bus.id_ctrl;
        r_regwrite <= bus.id_RegWrite & bus.id_valid & (bus.id_rd_addr != REG_X0);
        r_memread  <= bus.id_MemRead;
      end
    end
  end

  assign bus.EXE_valid    = r_valid;
  assign bus.EXE_pc       = r_pc;
  assign bus.EXE_rs1_addr = r_rs1_addr;
  assign bus.EXE_rs2_addr = r_rs2_addr;
  assign bus.EXE_rd_addr  = r_rd_addr;
  assign bus.EXE_rs1_data = r_rs1_data;
  assign bus.EXE_rs2_data = r_rs2_data;
  assign bus.EXE_imm      = r_imm;
  assign bus.EXE_ctrl     = r_ctrl;
  assign bus.EXE_RegWrite = r_regwrite;
  assign bus.EXE_MemRead  = r_memread;

`ifdef HAZ_PERF_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_lu    <= '0;
      r_perf_flush <= '0;
      r_perf_stall <= '0;
    end else if (bus.mem_stall) begin
      r_perf_stall <= sat_inc(r_perf_stall);
    end else if (bus.exe_flush) begin
      r_perf_flush <= sat_inc(r_perf_flush);
    end else if (w_hazard) begin
      r_perf_lu    <= sat_inc(r_perf_lu);
    end
  end

  assign perf_lu_bubbles   = r_perf_lu;
  assign perf_flushes      = r_perf_flush;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed bench for id_exe_stage: capture, x0 qualification, load-use bubble,
// false-hazard guards, flush priority, memory hold and asynchronous reset.
module tb_id_exe_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  id_exe_stage_if bus ();

`ifdef HAZ_PERF_EN
  logic [31:0] perf_lu_bubbles;
  logic [31:0] perf_flushes;
  logic [31:0] perf_stall_cycles;
`endif

  id_exe_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HAZ_PERF_EN
    ,
    .perf_lu_bubbles   (perf_lu_bubbles),
    .perf_flushes      (perf_flushes),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drive one decoded instruction into ID; data/imm/ctrl derive from the pc.
  task automatic drive_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic rs1u,
                          input logic [4:0] rs2, input logic rs2u,
                          input logic [4:0] rd, input logic rw, input logic mr);
    bus.id_valid    = v;
    bus.id_pc       = pc;
    bus.id_rs1_addr = rs1;
    bus.id_rs1_used = rs1u;
    bus.id_rs2_addr = rs2;
    bus.id_rs2_used = rs2u;
    bus.id_rd_addr  = rd;
    bus.id_RegWrite = rw;
    bus.id_MemRead  = mr;
    bus.id_rs1_data = pc ^ 32'hAAAA_0000;
    bus.id_rs2_data = pc ^ 32'h0000_5555;
    bus.id_imm      = pc + 32'd4;
    bus.id_ctrl     = ctrl_t'(pc[11:0] | 12'h801);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    bus.mem_stall = 1'b0;
    bus.exe_flush = 1'b0;
    drive_id(1'b1, 32'h40, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    check("reset_valid",  64'(bus.EXE_valid), 64'd0);
    check("reset_hold",   64'(bus.ifid_hold), 64'd0);
    check("reset_memrd",  64'(bus.EXE_MemRead), 64'd0);
    rst_n = 1'b1;

    // plain capture: add x3,x1,x2
    drive_id(1'b1, 32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    check("cap_valid",   64'(bus.EXE_valid), 64'd1);
    check("cap_pc",      64'(bus.EXE_pc), 64'h100);
    check("cap_rd",      64'(bus.EXE_rd_addr), 64'd3);
    check("cap_rs2",     64'(bus.EXE_rs2_addr), 64'd2);
    check("cap_regwr",   64'(bus.EXE_RegWrite), 64'd1);
    check("cap_rs1data", 64'(bus.EXE_rs1_data), 64'hAAAA_0100);
    check("cap_rs2data", 64'(bus.EXE_rs2_data), 64'h0000_5455);
    check("cap_imm",     64'(bus.EXE_imm), 64'h104);
    check("cap_ctrl",    64'(bus.EXE_ctrl), 64'h901);

    // addi x0: write-enable qualified off
    drive_id(1'b1, 32'h104, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    check("x0_regwr", 64'(bus.EXE_RegWrite), 64'd0);
    check("x0_valid", 64'(bus.EXE_valid), 64'd1);

    // invalid ID slot: RegWrite qualified off
    drive_id(1'b0, 32'h108, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    step();
    check("inv_valid", 64'(bus.EXE_valid), 64'd0);
    check("inv_regwr", 64'(bus.EXE_RegWrite), 64'd0);

    // load-use: lw x5 then add x6,x5,x7
    drive_id(1'b1, 32'h10C, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    check("lw_memrd", 64'(bus.EXE_MemRead), 64'd1);
    drive_id(1'b1, 32'h110, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    check("lu_hold", 64'(bus.ifid_hold), 64'd1);
    step();
    check("lu_bub_valid", 64'(bus.EXE_valid), 64'd0);
    check("lu_bub_regwr", 64'(bus.EXE_RegWrite), 64'd0);
    check("lu_bub_memrd", 64'(bus.EXE_MemRead), 64'd0);
    check("lu_bub_rs1",   64'(bus.EXE_rs1_addr), 64'd0);
    check("lu_hold_drop", 64'(bus.ifid_hold), 64'd0);
    step();
    check("lu_cap_rs1",   64'(bus.EXE_rs1_addr), 64'd5);
    check("lu_cap_valid", 64'(bus.EXE_valid), 64'd1);
    check("lu_cap_rd",    64'(bus.EXE_rd_addr), 64'd6);

    // load to x0 with ID reading x0: no stall
    drive_id(1'b1, 32'h114, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 32'h118, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    check("x0ld_hold", 64'(bus.ifid_hold), 64'd0);
    step();
    check("x0ld_pc", 64'(bus.EXE_pc), 64'h118);

    // rs2 matches but is unused (I-type): no stall
    drive_id(1'b1, 32'h11C, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 32'h120, 5'd1, 1'b1, 5'd5, 1'b0, 5'd8, 1'b1, 1'b0);
    settle();
    check("rs2u_hold", 64'(bus.ifid_hold), 64'd0);
    step();
    check("rs2u_rd", 64'(bus.EXE_rd_addr), 64'd8);

    // rs2 hazard path: lw x5; sw-like use of x5 through rs2
    drive_id(1'b1, 32'h124, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 32'h128, 5'd1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    check("rs2_hold", 64'(bus.ifid_hold), 64'd1);

    // flush beats hazard: lw x5 still in EX, ID reads x5, flush asserted
    bus.exe_flush = 1'b1;
    settle();
    check("fl_hold", 64'(bus.ifid_hold), 64'd0);
    step();
    bus.exe_flush = 1'b0;
    check("fl_valid", 64'(bus.EXE_valid), 64'd0);
    check("fl_ctrl",  64'(bus.EXE_ctrl), 64'd0);
    check("fl_rd",    64'(bus.EXE_rd_addr), 64'd0);

    // mem_stall holds across 3 cycles with ID changes and a flush pulse
    drive_id(1'b1, 32'h200, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 32'h204, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    bus.mem_stall = 1'b1;
    settle();
    check("ms_hold", 64'(bus.ifid_hold), 64'd0);
    step();
    check("ms_pc1", 64'(bus.EXE_pc), 64'h200);
    check("ms_memrd1", 64'(bus.EXE_MemRead), 64'd1);
    drive_id(1'b1, 32'h208, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0);
    bus.exe_flush = 1'b1;
    step();
    check("ms_pc2", 64'(bus.EXE_pc), 64'h200);
    check("ms_valid2", 64'(bus.EXE_valid), 64'd1);
    bus.exe_flush = 1'b0;
    drive_id(1'b1, 32'h204, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    step();
    check("ms_pc3", 64'(bus.EXE_pc), 64'h200);
    check("ms_rd3", 64'(bus.EXE_rd_addr), 64'd5);
    bus.mem_stall = 1'b0;
    settle();
    check("ms_rel_hold", 64'(bus.ifid_hold), 64'd1);
    step();
    check("ms_rel_bub", 64'(bus.EXE_valid), 64'd0);
    step();
    check("ms_rel_pc",  64'(bus.EXE_pc), 64'h204);
    check("ms_rel_val", 64'(bus.EXE_valid), 64'd1);

`ifdef HAZ_PERF_EN
    // events so far: load-use bubbles 2, row-2 flushes 1, stall cycles 3
    check("perf_lu",    64'(perf_lu_bubbles), 64'd2);
    check("perf_flush", 64'(perf_flushes), 64'd1);
    check("perf_stall", 64'(perf_stall_cycles), 64'd3);
`endif

    // asynchronous reset mid-cycle with a valid instruction in EX and ID
    drive_id(1'b1, 32'h300, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b1);
    step();
    check("pre_rst_valid", 64'(bus.EXE_valid), 64'd1);
    bus.mem_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.EXE_valid), 64'd0);
    check("arst_pc",    64'(bus.EXE_pc), 64'd0);
    check("arst_regwr", 64'(bus.EXE_RegWrite), 64'd0);
    check("arst_memrd", 64'(bus.EXE_MemRead), 64'd0);
    check("arst_rd",    64'(bus.EXE_rd_addr), 64'd0);
    check("arst_hold",  64'(bus.ifid_hold), 64'd0);
`ifdef HAZ_PERF_EN
    check("arst_perf", 64'(perf_stall_cycles), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
